// File: rtl/operand_entry_if.sv
// Button inputs and subtractor-facing outputs of the operand entry controller.
//   btn_inc_n, btn_next_n, btn_bin_n : raw active-low buttons (master -> slave)
//   a_val, b_val, borrow_in          : registered subtractor operands (slave -> master)
//   operands_valid                   : high while the SHOW phase is active
//   phase_led                        : one-hot phase {SHOW, ENTER_B, ENTER_A}
interface operand_entry_if;
    logic       btn_inc_n;
    logic       btn_next_n;
    logic       btn_bin_n;
    logic [3:0] a_val;
    logic [3:0] b_val;
    logic       borrow_in;
    logic       operands_valid;
    logic [2:0] phase_led;

    modport master (
        output btn_inc_n, btn_next_n, btn_bin_n,
        input  a_val, b_val, borrow_in, operands_valid, phase_led
    );

    modport slave (
        input  btn_inc_n, btn_next_n, btn_bin_n,
        output a_val, b_val, borrow_in, operands_valid, phase_led
    );
endinterface

// File: rtl/operand_entry.sv
// Debounces three push-buttons and walks the user through entering two 4-bit
// operands and a borrow-in bit for the board's 4-bit subtractor.
//   clk : system clock, rising edge
//   rst : synchronous reset, active-high
//   bus : operand_entry_if.slave (raw buttons in, registered operands/status out)
module operand_entry #(
    parameter int unsigned DEBOUNCE_CYCLES = 270000
) (
    input  logic              clk,
    input  logic              rst,
    operand_entry_if.slave    bus
);
    localparam int unsigned NUM_BTN = 3;
    localparam int unsigned CNT_W   = 24;
    localparam int unsigned DATA_W  = 4;
    localparam int unsigned PHASE_W = 3;
    localparam int unsigned BTN_INC  = 0;
    localparam int unsigned BTN_NEXT = 1;
    localparam int unsigned BTN_BIN  = 2;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        ENTER_A = 2'd0,
        ENTER_B = 2'd1,
        SHOW    = 2'd2
    } stateType;

    logic [NUM_BTN-1:0] rawN;
    logic [NUM_BTN-1:0] sync1;
    logic [NUM_BTN-1:0] sync2;
    logic [NUM_BTN-1:0] stableLvl;
    logic [NUM_BTN-1:0] stablePrev;
    logic [NUM_BTN-1:0] pressEvt;
    logic [CNT_W-1:0]   cnt [NUM_BTN];

    stateType           state, stateNext;
    logic [DATA_W-1:0]  aReg, aNext;
    logic [DATA_W-1:0]  bReg, bNext;
    logic               borReg, borNext;
    logic               validReg, validNext;
    logic [PHASE_W-1:0] ledReg, ledNext;

    assign rawN = {bus.btn_bin_n, bus.btn_next_n, bus.btn_inc_n};

    // Synchronise, debounce and edge-detect each button; all lanes are identical.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1      <= '1;
            sync2      <= '1;
            stableLvl  <= '1;
            stablePrev <= '1;
            pressEvt   <= '0;
            for (int i = 0; i < NUM_BTN; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            sync1      <= rawN;
            sync2      <= sync1;
            stablePrev <= stableLvl;
            // Registered press pulse: stable level fell on the previous edge.
            pressEvt   <= stablePrev & ~stableLvl;
            for (int i = 0; i < NUM_BTN; i++) begin
                if (sync2[i] == stableLvl[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    stableLvl[i] <= sync2[i];
                    cnt[i]       <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    // Phase state and operand registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ENTER_A;
            aReg     <= '0;
            bReg     <= '0;
            borReg   <= 1'b0;
            validReg <= 1'b0;
            ledReg   <= PHASE_W'(1);
        end else begin
            state    <= stateNext;
            aReg     <= aNext;
            bReg     <= bNext;
            borReg   <= borNext;
            validReg <= validNext;
            ledReg   <= ledNext;
        end
    end

    // Next phase and operand values; next beats inc, borrow toggle uses the current phase.
    always_comb begin
        stateNext = state;
        aNext     = aReg;
        bNext     = bReg;
        borNext   = borReg;

        if (pressEvt[BTN_BIN] && (state != SHOW)) begin
            borNext = ~borReg;
        end

        unique case (state)
            ENTER_A: begin
                if (pressEvt[BTN_NEXT]) begin
                    stateNext = ENTER_B;
                end else if (pressEvt[BTN_INC]) begin
                    aNext = aReg + DATA_W'(1);
                end
            end
            ENTER_B: begin
                if (pressEvt[BTN_NEXT]) begin
                    stateNext = SHOW;
                end else if (pressEvt[BTN_INC]) begin
                    bNext = bReg + DATA_W'(1);
                end
            end
            SHOW: begin
                if (pressEvt[BTN_NEXT]) begin
                    stateNext = ENTER_A;
                    aNext     = '0;
                    bNext     = '0;
                    borNext   = 1'b0;
                end
            end
            default: begin
                stateNext = ENTER_A;
            end
        endcase

        validNext = (stateNext == SHOW);
        unique case (stateNext)
            ENTER_A: ledNext = 3'b001;
            ENTER_B: ledNext = 3'b010;
            SHOW:    ledNext = 3'b100;
            default: ledNext = 3'b001;
        endcase
    end

    assign bus.a_val          = aReg;
    assign bus.b_val          = bReg;
    assign bus.borrow_in      = borReg;
    assign bus.operands_valid = validReg;
    assign bus.phase_led      = ledReg;
endmodule

// File: tb/tb_operand_entry.sv
// Randomised scoreboard bench for operand_entry with a short debounce window.
module tb_operand_entry;
    localparam int unsigned D = 4;
    localparam logic [12:0] RESET_TUPLE = {4'd0, 4'd0, 1'b0, 1'b0, 3'b001};

    logic clk;
    logic rst;
    operand_entry_if ifc ();

    operand_entry #(.DEBOUNCE_CYCLES(D)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    logic [12:0] expQ [$];
    logic [12:0] lastExp;
    logic [12:0] prevSeen;
    bit          monOn = 1'b0;

    // Reference model: phase 0=ENTER_A, 1=ENTER_B, 2=SHOW
    int mA, mB, mBor, mPhase;

    function automatic logic [12:0] modelTuple();
        logic [2:0] led;
        led = 3'b001 << mPhase;
        return {4'(mA), 4'(mB), 1'(mBor), (mPhase == 2), led};
    endfunction

    function automatic logic [12:0] dutTuple();
        return {ifc.a_val, ifc.b_val, ifc.borrow_in, ifc.operands_valid, ifc.phase_led};
    endfunction

    task automatic pushIfChanged();
        logic [12:0] t;
        t = modelTuple();
        if (t != lastExp) begin
            expQ.push_back(t);
            lastExp = t;
        end
    endtask

    // Accepted events arriving together: mask bit0 inc, bit1 next, bit2 bin
    task automatic applyEvents(input logic [2:0] mask);
        if (mask[2] && mPhase != 2) mBor = 1 - mBor;
        if (mask[1]) begin
            if (mPhase == 2) begin
                mPhase = 0; mA = 0; mB = 0; mBor = 0;
            end else begin
                mPhase = mPhase + 1;
            end
        end else if (mask[0]) begin
            if (mPhase == 0) mA = (mA + 1) % 16;
            else if (mPhase == 1) mB = (mB + 1) % 16;
        end
        pushIfChanged();
    endtask

    task automatic modelReset();
        mA = 0; mB = 0; mBor = 0; mPhase = 0;
        pushIfChanged();
    endtask

    task automatic check(input string name, input logic [12:0] act, input logic [12:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic setButtons(input logic [2:0] mask);
        ifc.btn_inc_n  = ~mask[0];
        ifc.btn_next_n = ~mask[1];
        ifc.btn_bin_n  = ~mask[2];
    endtask

    // Called at a negedge; holds the buttons in mask low, then releases.
    task automatic press(input logic [2:0] mask, input int hold, input int rel);
        if (hold >= int'(D)) applyEvents(mask);
        setButtons(mask);
        repeat (hold) @(negedge clk);
        setButtons(3'b000);
        repeat (rel) @(negedge clk);
    endtask

    task automatic doReset();
        rst = 1'b1;
        modelReset();
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    // Monitor: every change on the outputs must match the next queued expectation.
    always @(negedge clk) begin
        logic [12:0] cur;
        if (monOn) begin
            cur = dutTuple();
            if (cur !== prevSeen) begin
                if (expQ.size() == 0) begin
                    check("unexpected_change", cur, prevSeen);
                end else begin
                    check("scoreboard", cur, expQ.pop_front());
                end
                prevSeen = cur;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        setButtons(3'b000);
        mA = 0; mB = 0; mBor = 0; mPhase = 0;
        lastExp = RESET_TUPLE;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset_state", dutTuple(), RESET_TUPLE);
        prevSeen = dutTuple();
        monOn = 1'b1;

        // Latency: a_val changes on the 8th edge after the raw edge.
        applyEvents(3'b001);
        ifc.btn_inc_n = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk);
            #1;
            if (i == 7) check("latency_before", 13'(ifc.a_val), 13'd0);
            if (i == 8) check("latency_at", 13'(ifc.a_val), 13'd1);
        end
        @(negedge clk);
        repeat (11) @(negedge clk);
        ifc.btn_inc_n = 1'b1;
        repeat (10) @(negedge clk);
        check("held_once", dutTuple(), {4'd1, 4'd0, 1'b0, 1'b0, 3'b001});

        // Bounce shorter than the window is ignored.
        press(3'b001, 3, 1);
        press(3'b001, 3, 8);
        check("bounce_ignored", dutTuple(), modelTuple());
        press(3'b001, 10, 8);
        check("after_bounce", dutTuple(), {4'd2, 4'd0, 1'b0, 1'b0, 3'b001});

        // Sixteen increments wrap a_val back to zero.
        doReset();
        for (int i = 0; i < 16; i++) press(3'b001, D + 1, D + 1);
        check("wrap", dutTuple(), RESET_TUPLE);

        // Full entry sequence.
        doReset();
        repeat (3) press(3'b001, D + 2, D + 2);
        press(3'b010, D + 2, D + 2);
        repeat (5) press(3'b001, D + 2, D + 2);
        press(3'b100, D + 2, D + 2);
        press(3'b010, D + 2, D + 2);
        check("show_values", dutTuple(), {4'd3, 4'd5, 1'b1, 1'b1, 3'b100});
        press(3'b001, D + 2, D + 2);
        check("show_inc_ignored", dutTuple(), {4'd3, 4'd5, 1'b1, 1'b1, 3'b100});
        press(3'b010, D + 2, D + 2);
        check("show_clear", dutTuple(), RESET_TUPLE);

        // inc and next together: next wins.
        doReset();
        press(3'b001, D + 2, D + 2);
        press(3'b011, D + 2, D + 2);
        check("next_priority", dutTuple(), {4'd1, 4'd0, 1'b0, 1'b0, 3'b010});

        // Reset while a debounce is mid-count in ENTER_B.
        ifc.btn_next_n = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        modelReset();
        @(negedge clk);
        rst = 1'b0;
        ifc.btn_next_n = 1'b1;
        repeat (12) @(negedge clk);
        check("reset_midcount", dutTuple(), RESET_TUPLE);
        press(3'b010, D + 2, D + 2);
        check("repress_after_reset", dutTuple(), {4'd0, 4'd0, 1'b0, 1'b0, 3'b010});

        // Random presses, glitches, combinations and occasional resets.
        for (int i = 0; i < 80; i++) begin
            logic [2:0] mask;
            int hold;
            int rel;
            mask = 3'($urandom_range(1, 7));
            hold = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, D - 1))
                                               : int'($urandom_range(D, D + 5));
            rel  = int'($urandom_range(D, D + 5));
            if ($urandom_range(0, 14) == 0) doReset();
            else press(mask, hold, rel);
        end
        repeat (10) @(negedge clk);
        check("random_final", dutTuple(), modelTuple());
        check("queue_drained", 13'(expQ.size()), 13'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/operand_entry.md
Name: operand_entry

Overview:
- Button-driven operand entry controller on the Gowin board.
- Debounces three raw push-buttons and steps the user through entering two 4-bit operands plus a borrow-in bit.
- Presents the operands as registered values directly to the 4-bit subtractor inputs (A, B, BorrowIN).
- Drives status LEDs showing the current entry phase.

Parameters:
- DEBOUNCE_CYCLES, 270000, consecutive cycles a synchronized button level must differ from the stable level before it is accepted (10 ms at 27 MHz); legal range 2..2^24-1.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous reset, active-high.
- btn_inc_n  input  1  raw increment button, active-low, asynchronous to clk.
- btn_next_n  input  1  raw advance button, active-low, asynchronous.
- btn_bin_n  input  1  raw borrow-toggle button, active-low, asynchronous.
- a_val  output  4  operand A to subtractor.
- b_val  output  4  operand B to subtractor.
- borrow_in  output  1  BorrowIN to subtractor.
- operands_valid  output  1  high while in SHOW; subtractor result is meaningful.
- phase_led  output  3  one-hot phase: bit0 ENTER_A, bit1 ENTER_B, bit2 SHOW.

Behaviour:
- Reset (rst high at an edge) sets:
  - a_val=0, b_val=0, borrow_in=0, operands_valid=0, phase_led=3'b001, state ENTER_A.
  - All synchronizer flops and stable levels = released (1).
  - Debounce counters = 0; pending events cleared.
  - Reset mid-operation discards any in-progress debounce.
- Per button, in identical independent instances:
  - 2-FF synchronizer, output s2.
  - Debounce counter:
    - If s2 == stable: counter := 0.
    - Otherwise counter increments each cycle.
    - When counter == DEBOUNCE_CYCLES-1 with s2 still differing: stable := s2, counter := 0.
    - Glitches shorter than DEBOUNCE_CYCLES are ignored; the counter restarts on any bounce back.
  - Press event: one-cycle registered pulse when stable goes 1->0. Release produces no event.
  - Holding a button generates exactly one event.
- Latency:
  - Raw falling edge held steady -> stable changes at edge 2+DEBOUNCE_CYCLES -> event pulse high after edge 3+DEBOUNCE_CYCLES.
  - Outputs update at edge 4+DEBOUNCE_CYCLES.
- FSM, states ENTER_A, ENTER_B, SHOW:
  - ENTER_A:
    - inc event: a_val := a_val+1 mod 16 (15 wraps to 0).
    - next event -> ENTER_B.
  - ENTER_B:
    - inc event: b_val := b_val+1 mod 16.
    - next event -> SHOW.
  - SHOW:
    - inc events ignored.
    - next event -> ENTER_A, with a_val, b_val, borrow_in cleared to 0 on the same edge.
  - bin event: toggles borrow_in in ENTER_A and ENTER_B; ignored in SHOW.
- Simultaneous events in the same cycle:
  - next has priority; inc is dropped.
  - bin and next together: toggle applies using the pre-transition state, then the state advances.
    - In ENTER_B, toggle and transition to SHOW both occur.
    - In SHOW, the clear wins.
- operands_valid = 1 exactly while state == SHOW; phase_led is one-hot of state.
- All outputs are registered; there is no combinational path from buttons to outputs.
- Values are held indefinitely between events.

Test Plan:
- DEBOUNCE_CYCLES=4, reset, hold btn_inc_n low 20 cycles -> a_val goes 0->1 exactly 8 cycles after the raw edge, stays 1; b_val=0, phase_led=001.
- Bounce: btn_inc_n low 3 cycles, high 1, low 3, high -> a_val stays 0; then low steadily -> single increment.
- 16 clean inc presses in ENTER_A -> a_val 1..15 then wraps to 0.
- Full sequence, with each press followed by a release of ≥ DEBOUNCE_CYCLES cycles so that each press produces a new event:
  - Steps: 3 inc, next, 5 inc, bin, next.
  - Result: a_val=3, b_val=5, borrow_in=1, operands_valid=1, phase_led=100.
  - Then inc -> no change; then next -> all zero, ENTER_A.
- inc and next raw edges aligned in ENTER_A -> state ENTER_B, a_val unchanged.
- Assert rst during ENTER_B with a debounce counter mid-count -> next edge all outputs at reset values; no event emitted afterwards from that press until it is released and re-pressed.
